// File: rtl/taillight_input_cond_if.sv
// Raw stalk/button inputs and conditioned requests for the taillight input conditioner.
interface taillight_input_cond_if;
  logic left_raw_i;
  logic right_raw_i;
  logic hazard_btn_i;
  logic left_o;
  logic right_o;
  logic hazard_o;
  logic hazard_press_o;

  // Driver side: owns the raw contacts, observes the conditioned requests.
  modport master (
    output left_raw_i, right_raw_i, hazard_btn_i,
    input  left_o, right_o, hazard_o, hazard_press_o
  );

  // Conditioner side.
  modport slave (
    input  left_raw_i, right_raw_i, hazard_btn_i,
    output left_o, right_o, hazard_o, hazard_press_o
  );
endinterface

// File: rtl/taillight_input_cond.sv
// Synchronises and debounces the turn stalk and hazard button, and turns hazard
// button presses into a one-cycle pulse plus an optional latched hazard mode.
module taillight_input_cond #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HAZARD_TOGGLE   = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  taillight_input_cond_if.slave bus
);

  localparam int unsigned NCH   = 3;
  localparam int unsigned CH_L  = 0;
  localparam int unsigned CH_R  = 1;
  localparam int unsigned CH_H  = 2;
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0]         w_raw;
  logic [SYNC_STAGES-1:0] r_sync [NCH];
  logic [NCH-1:0]         r_stable;
  logic [CNT_W-1:0]       r_cnt  [NCH];
  logic                   r_hz_prev;
  logic                   r_press;
  logic                   r_latch;

  assign w_raw = {bus.hazard_btn_i, bus.right_raw_i, bus.left_raw_i};

  // Plain shift-register synchroniser per channel; bit SYNC_STAGES-1 is the synced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) r_sync[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++)
        r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], w_raw[c]};
    end
  end

  // Accept a new level only after it has differed from stable for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
      for (int c = 0; c < NCH; c++) r_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (r_sync[c][SYNC_STAGES-1] == r_stable[c]) begin
          r_cnt[c] <= '0;
        end else if (r_cnt[c] == CNT_MAX) begin
          r_stable[c] <= r_sync[c][SYNC_STAGES-1];
          r_cnt[c]    <= '0;
        end else begin
          r_cnt[c] <= r_cnt[c] + CNT_W'(1);
        end
      end
    end
  end

  // Rising edge of debounced hazard gives the press pulse; the latch flips with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hz_prev <= 1'b0;
      r_press   <= 1'b0;
      r_latch   <= 1'b0;
    end else begin
      r_hz_prev <= r_stable[CH_H];
      r_press   <= r_stable[CH_H] & ~r_hz_prev;
      if (r_stable[CH_H] & ~r_hz_prev) r_latch <= ~r_latch;
    end
  end

  // Both stalk directions at once pass straight through; the sequencer resolves it.
  assign bus.left_o         = r_stable[CH_L];
  assign bus.right_o        = r_stable[CH_R];
  assign bus.hazard_press_o = r_press;
  assign bus.hazard_o       = (HAZARD_TOGGLE != 0) ? r_latch : r_stable[CH_H];

endmodule
